control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute FSM that directly consumes the Instruction Register outputs (opcode, address) and drives loadIR, PC, memory, accumulator and ALU controls.
- Sits between the IR and the datapath of the 16-bit computer.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- DATA_WIDTH, 16, machine word width (from CPU_package).
- ALU_OPCODE, 4, opcode field is ALU_OPCODE+1 = 5 bits; address field is DATA_WIDTH-ALU_OPCODE-1 = 11 bits.
- CNT_WIDTH, 16, retired-instruction counter width.

Ports:
- iclk  in  1  system clock, rising edge.
- irst_n  in  1  asynchronous, active-low reset.
- irun  in  1  run enable; sampled only in S_FETCH.
- opcode  in  5  IR opcode field.
- address  in  11  IR address field; used only by the datapath, passed through as ir_addr.
- zero_flag  in  1  accumulator == 0, registered in the datapath.
- carry_flag  in  1  last ALU carry, registered in the datapath.
- loadIR  out  1  IR load strobe.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= ir_addr.
- addr_sel  out  1  memory address source: 0 = PC, 1 = IR address.
- mem_rd  out  1  synchronous memory read; data valid the next cycle.
- mem_wr  out  1  memory write of the accumulator.
- acc_load  out  1  accumulator write enable.
- acc_src  out  2  accumulator source: 0 = ALU, 1 = memory, 2 = immediate (zero-extended ir_addr).
- alu_sel  out  4  ALU function.
- out_load  out  1  output register load.
- ir_addr  out  11  registered copy of address, captured in S_DECODE.
- halted  out  1  high while in S_HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- retired  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: async on irst_n low. State S_FETCH, all outputs 0, retired = 0.
- All control outputs are Moore-decoded from the state and registered opcode. Unlisted outputs are 0 in every state.
- IR timing is fixed: opcode/address are valid 2 cycles after the loadIR cycle. The FSM therefore inserts exactly one wait state.
- States:
  - S_FETCH: if irun, assert addr_sel=0 and mem_rd, then go to S_LOADIR. Otherwise stay and drive all outputs 0.
  - S_LOADIR: assert loadIR and pc_inc. Next state is S_WAIT.
  - S_WAIT: no outputs. Next state is S_DECODE.
  - S_DECODE: capture ir_addr and opcode internally, then branch:
    - NOP(0): go to S_FETCH.
    - LDA(1), ADD(3), SUB(4), AND(5), OR(6), XOR(7): go to S_MEMRD.
    - STA(2): go to S_STORE.
    - NOT(8): go to S_ALU.
    - JMP(9): go to S_JUMP.
    - JZ(10): go to S_JUMP if zero_flag, else S_FETCH.
    - JC(11): go to S_JUMP if carry_flag, else S_FETCH.
    - LDI(12): go to S_IMM.
    - OUT(13): go to S_OUT.
    - HLT(31): go to S_HALT.
    - Opcodes 14–30: pulse illegal, treat as NOP and go to S_FETCH.
  - S_MEMRD: addr_sel=1, mem_rd. Next state is S_LDA for LDA, else S_ALU.
  - S_LDA: acc_load, acc_src=1.
  - S_ALU: acc_load, acc_src=0, alu_sel from the package map.
  - S_STORE: addr_sel=1, mem_wr.
  - S_IMM: acc_load, acc_src=2.
  - S_OUT: out_load.
  - S_JUMP: pc_load.
  - S_LDA, S_ALU, S_STORE, S_IMM, S_OUT and S_JUMP all go to S_FETCH.
  - S_HALT: halted=1. Exit only by reset.
- retired increments by 1 on every transition into S_FETCH from an instruction, including NOP, illegal and not-taken branches. It wraps modulo 2^CNT_WIDTH. HLT does not count.
- Flags are sampled only in S_DECODE; later changes are ignored.
- irun falling mid-instruction does not stall; the current instruction completes and the FSM parks in S_FETCH.
- Reset mid-instruction aborts immediately. No partial mem_wr or pc_load may follow reset release.
- Instruction length in cycles, from the S_FETCH cycle with irun=1 to the next S_FETCH:
  - NOP, illegal and not-taken branches: 4.
  - STA, NOT, LDI, OUT and taken jumps: 5.
  - LDA and two-operand ALU ops: 6.

Decomposition:
- CPU_package gets:
  - opcode enum op_e (5-bit) with the values above.
  - state enum ctrl_state_e.
  - alu_sel_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5.
  - acc_src_e.
  - function op_to_alu(op_e) returning alu_sel_e.
- Single module; no sub-module warranted.

Test Plan:
- Reset with irun=1, opcode=0 (NOP) -> fetch pulse sequence mem_rd, then loadIR+pc_inc, then 4-cycle loop; retired = 3 after 12 cycles.
- opcode=LDA(1), address=0x05A -> ir_addr=0x05A; S_MEMRD addr_sel=1, mem_rd=1; next cycle acc_load=1, acc_src=1; 6-cycle instruction.
- opcode=JZ(10), zero_flag=1, then zero_flag=0 -> first pc_load=1 in cycle 5; second no pc_load, back to fetch in 4 cycles; retired +2.
- opcode=14 -> illegal pulses exactly 1 cycle in S_DECODE, no datapath strobe, retired +1.
- opcode=HLT(31) -> halted=1 held for 20 cycles, retired unchanged; irst_n low for 1 cycle mid-S_STORE -> all outputs 0 immediately, FSM resumes at S_FETCH.
- irun=0 in S_FETCH for 5 cycles -> no mem_rd; irun dropped during SUB(4) -> SUB completes with alu_sel=1, then FSM parks.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types for the 16-bit CPU control sequencer: opcodes, FSM states,
// ALU/accumulator selectors and the per-state control decode.
package control_sequencer_pkg;

   typedef enum logic [4:0] {
      OP_NOP = 5'd0,
      OP_LDA = 5'd1,
      OP_STA = 5'd2,
      OP_ADD = 5'd3,
      OP_SUB = 5'd4,
      OP_AND = 5'd5,
      OP_OR  = 5'd6,
      OP_XOR = 5'd7,
      OP_NOT = 5'd8,
      OP_JMP = 5'd9,
      OP_JZ  = 5'd10,
      OP_JC  = 5'd11,
      OP_LDI = 5'd12,
      OP_OUT = 5'd13,
      OP_HLT = 5'd31
   } op_e;

   typedef enum logic [3:0] {
      S_FETCH,
      S_LOADIR,
      S_WAIT,
      S_DECODE,
      S_MEMRD,
      S_LDA,
      S_ALU,
      S_STORE,
      S_IMM,
      S_OUT,
      S_JUMP,
      S_HALT
   } ctrl_state_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_NOT = 4'd5
   } alu_sel_e;

   typedef enum logic [1:0] {
      ACC_ALU = 2'd0,
      ACC_MEM = 2'd1,
      ACC_IMM = 2'd2
   } acc_src_e;

   typedef struct packed {
      logic     loadIR;
      logic     pc_inc;
      logic     pc_load;
      logic     addr_sel;
      logic     mem_rd;
      logic     mem_wr;
      logic     acc_load;
      acc_src_e acc_src;
      alu_sel_e alu_sel;
      logic     out_load;
      logic     halted;
   } ctrl_out_t;

   function automatic alu_sel_e op_to_alu(input op_e op);
      alu_sel_e sel;
      case (op)
         OP_SUB:  sel = ALU_SUB;
         OP_AND:  sel = ALU_AND;
         OP_OR:   sel = ALU_OR;
         OP_XOR:  sel = ALU_XOR;
         OP_NOT:  sel = ALU_NOT;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

   // Control word asserted for the whole time the FSM sits in state st.
   function automatic ctrl_out_t ctrl_decode(input ctrl_state_e st, input op_e op);
      ctrl_out_t c;
      c = '0;
      case (st)
         S_LOADIR: begin
            c.loadIR = 1'b1;
            c.pc_inc = 1'b1;
         end
         S_MEMRD: begin
            c.addr_sel = 1'b1;
            c.mem_rd   = 1'b1;
         end
         S_LDA: begin
            c.acc_load = 1'b1;
            c.acc_src  = ACC_MEM;
         end
         S_ALU: begin
            c.acc_load = 1'b1;
            c.acc_src  = ACC_ALU;
            c.alu_sel  = op_to_alu(op);
         end
         S_STORE: begin
            c.addr_sel = 1'b1;
            c.mem_wr   = 1'b1;
         end
         S_IMM: begin
            c.acc_load = 1'b1;
            c.acc_src  = ACC_IMM;
         end
         S_OUT:   c.out_load = 1'b1;
         S_JUMP:  c.pc_load  = 1'b1;
         S_HALT:  c.halted   = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit CPU: drives IR, PC, memory,
// accumulator and ALU controls, counts retired instructions, flags bad opcodes.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ALU_OPCODE = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                                iclk,
   input  logic                                irst_n,
   input  logic                                irun,
   input  logic [ALU_OPCODE:0]                 opcode,
   input  logic [DATA_WIDTH-ALU_OPCODE-2:0]    address,
   input  logic                                zero_flag,
   input  logic                                carry_flag,
   output logic                                loadIR,
   output logic                                pc_inc,
   output logic                                pc_load,
   output logic                                addr_sel,
   output logic                                mem_rd,
   output logic                                mem_wr,
   output logic                                acc_load,
   output logic [1:0]                          acc_src,
   output logic [3:0]                          alu_sel,
   output logic                                out_load,
   output logic [DATA_WIDTH-ALU_OPCODE-2:0]    ir_addr,
   output logic                                halted,
   output logic                                illegal,
   output logic [CNT_WIDTH-1:0]                retired
);

   ctrl_state_e                            r_state;
   ctrl_state_e                            w_next;
   op_e                                    r_op;
   op_e                                    w_op_now;
   ctrl_out_t                              r_out;
   logic [DATA_WIDTH-ALU_OPCODE-2:0]       r_ir_addr;
   logic [CNT_WIDTH-1:0]                   r_retired;
   logic                                   w_illegal;
   logic                                   w_retire;
   logic                                   w_fetch_rd;

   always_comb begin
      // IR fields are only valid in S_DECODE; afterwards the captured opcode is used.
      w_op_now  = (r_state == S_DECODE) ? op_e'(opcode) : r_op;
      w_next    = r_state;
      w_illegal = 1'b0;
      case (r_state)
         S_FETCH:  if (irun) w_next = S_LOADIR;
         S_LOADIR: w_next = S_WAIT;
         S_WAIT:   w_next = S_DECODE;
         S_DECODE: begin
            case (w_op_now)
               OP_NOP: w_next = S_FETCH;
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                       w_next = S_MEMRD;
               OP_STA: w_next = S_STORE;
               OP_NOT: w_next = S_ALU;
               OP_JMP: w_next = S_JUMP;
               OP_JZ:  w_next = zero_flag  ? S_JUMP : S_FETCH;
               OP_JC:  w_next = carry_flag ? S_JUMP : S_FETCH;
               OP_LDI: w_next = S_IMM;
               OP_OUT: w_next = S_OUT;
               OP_HLT: w_next = S_HALT;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMRD:  w_next = (r_op == OP_LDA) ? S_LDA : S_ALU;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
      w_retire   = (w_next == S_FETCH) && (r_state != S_FETCH);
      // The fetch read depends on irun in the same cycle, so it is the one
      // combinational strobe; it is forced low while reset is held.
      w_fetch_rd = (r_state == S_FETCH) && irun && irst_n;
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_state   <= S_FETCH;
         r_op      <= OP_NOP;
         r_out     <= '0;
         r_ir_addr <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_out   <= ctrl_decode(w_next, w_op_now);
         if (r_state == S_DECODE) begin
            r_op      <= op_e'(opcode);
            r_ir_addr <= address;
         end
         if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
      end
   end

   assign loadIR   = r_out.loadIR;
   assign pc_inc   = r_out.pc_inc;
   assign pc_load  = r_out.pc_load;
   assign addr_sel = r_out.addr_sel;
   assign mem_rd   = r_out.mem_rd | w_fetch_rd;
   assign mem_wr   = r_out.mem_wr;
   assign acc_load = r_out.acc_load;
   assign acc_src  = r_out.acc_src;
   assign alu_sel  = r_out.alu_sel;
   assign out_load = r_out.out_load;
   assign halted   = r_out.halted;
   assign illegal  = w_illegal;
   assign ir_addr  = r_ir_addr;
   assign retired  = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle control-word checks against
// hand-computed vectors, plus retired-count and ir_addr checks.
module tb_control_sequencer;

   logic        iclk;
   logic        irst_n;
   logic        irun;
   logic [4:0]  opcode;
   logic [10:0] address;
   logic        zero_flag;
   logic        carry_flag;
   logic        loadIR, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load;
   logic [1:0]  acc_src;
   logic [3:0]  alu_sel;
   logic        out_load, halted, illegal;
   logic [10:0] ir_addr;
   logic [15:0] retired;

   control_sequencer #(
      .DATA_WIDTH (16),
      .ALU_OPCODE (4),
      .CNT_WIDTH  (16)
   ) dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .irun       (irun),
      .opcode     (opcode),
      .address    (address),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .loadIR     (loadIR),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .addr_sel   (addr_sel),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .acc_load   (acc_load),
      .acc_src    (acc_src),
      .alu_sel    (alu_sel),
      .out_load   (out_load),
      .ir_addr    (ir_addr),
      .halted     (halted),
      .illegal    (illegal),
      .retired    (retired)
   );

   // {loadIR,pc_inc,pc_load,addr_sel,mem_rd,mem_wr,acc_load,acc_src[1:0],alu_sel[3:0],out_load,halted,illegal}
   logic [15:0] ctl;
   assign ctl = {loadIR, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_load,
                 acc_src, alu_sel, out_load, halted, illegal};

   localparam logic [15:0] C_NONE   = 16'h0000;
   localparam logic [15:0] C_FETCH  = 16'h0800;
   localparam logic [15:0] C_LOADIR = 16'hC000;
   localparam logic [15:0] C_MEMRD  = 16'h1800;
   localparam logic [15:0] C_LDA    = 16'h0280;
   localparam logic [15:0] C_STORE  = 16'h1400;
   localparam logic [15:0] C_IMM    = 16'h0300;
   localparam logic [15:0] C_OUT    = 16'h0004;
   localparam logic [15:0] C_JUMP   = 16'h2000;
   localparam logic [15:0] C_HALT   = 16'h0002;
   localparam logic [15:0] C_ILL    = 16'h0001;
   localparam logic [15:0] C_ADD    = 16'h0200;
   localparam logic [15:0] C_SUB    = 16'h0208;
   localparam logic [15:0] C_NOT    = 16'h0228;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [15:0] exp_ret = '0;

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Check the control word 1ns after the falling edge, then advance one cycle.
   task automatic cyc(input string tag, input logic [15:0] exp);
      #1 chk(tag, {16'h0, ctl}, {16'h0, exp});
      @(negedge iclk);
   endtask

   task automatic instr(input string tag, input logic [4:0] op, input logic [10:0] adr,
                        input logic zf, input logic cf, input logic [15:0] e_dec,
                        input logic [15:0] e5, input logic [15:0] e6, input int unsigned len);
      opcode     = op;
      address    = adr;
      zero_flag  = zf;
      carry_flag = cf;
      cyc({tag, "_fetch"}, C_FETCH);
      cyc({tag, "_loadir"}, C_LOADIR);
      cyc({tag, "_wait"}, C_NONE);
      cyc({tag, "_decode"}, e_dec);
      if (len >= 5) cyc({tag, "_c5"}, e5);
      if (len >= 6) cyc({tag, "_c6"}, e6);
      exp_ret = exp_ret + 16'd1;
      #1 chk({tag, "_retired"}, {16'h0, retired}, {16'h0, exp_ret});
   endtask

   initial begin
      irst_n     = 1'b0;
      irun       = 1'b1;
      opcode     = 5'd0;
      address    = '0;
      zero_flag  = 1'b0;
      carry_flag = 1'b0;
      @(negedge iclk);
      @(negedge iclk);
      #1 chk("rst_ctl", {16'h0, ctl}, 32'h0);
      chk("rst_retired", {16'h0, retired}, 32'h0);
      chk("rst_iraddr", {21'h0, ir_addr}, 32'h0);
      @(negedge iclk);
      irst_n = 1'b1;

      // Three back-to-back NOPs: 12 cycles, retired = 3.
      for (int unsigned i = 0; i < 3; i++) begin
         cyc("nop_fetch", C_FETCH);
         cyc("nop_loadir", C_LOADIR);
         cyc("nop_wait", C_NONE);
         cyc("nop_decode", C_NONE);
      end
      exp_ret = 16'd3;
      #1 chk("nop_retired", {16'h0, retired}, 32'd3);

      instr("lda", 5'd1, 11'h05A, 1'b0, 1'b0, C_NONE, C_MEMRD, C_LDA, 6);
      chk("lda_iraddr", {21'h0, ir_addr}, 32'h05A);
      instr("jz_t", 5'd10, 11'h123, 1'b1, 1'b0, C_NONE, C_JUMP, C_NONE, 5);
      chk("jz_iraddr", {21'h0, ir_addr}, 32'h123);
      instr("jz_n", 5'd10, 11'h124, 1'b0, 1'b1, C_NONE, C_NONE, C_NONE, 4);
      instr("jc_t", 5'd11, 11'h300, 1'b0, 1'b1, C_NONE, C_JUMP, C_NONE, 5);
      instr("jc_n", 5'd11, 11'h301, 1'b1, 1'b0, C_NONE, C_NONE, C_NONE, 4);
      instr("ill14", 5'd14, 11'h000, 1'b0, 1'b0, C_ILL, C_NONE, C_NONE, 4);
      instr("ill30", 5'd30, 11'h000, 1'b0, 1'b0, C_ILL, C_NONE, C_NONE, 4);
      instr("not", 5'd8, 11'h000, 1'b0, 1'b0, C_NONE, C_NOT, C_NONE, 5);
      instr("sta", 5'd2, 11'h7FF, 1'b0, 1'b0, C_NONE, C_STORE, C_NONE, 5);
      instr("ldi", 5'd12, 11'h055, 1'b0, 1'b0, C_NONE, C_IMM, C_NONE, 5);
      instr("out", 5'd13, 11'h000, 1'b0, 1'b0, C_NONE, C_OUT, C_NONE, 5);
      instr("add", 5'd3, 11'h010, 1'b0, 1'b0, C_NONE, C_MEMRD, C_ADD, 6);
      instr("jmp", 5'd9, 11'h400, 1'b0, 1'b0, C_NONE, C_JUMP, C_NONE, 5);

      // irun low while parked: no fetch for 5 cycles.
      irun = 1'b0;
      for (int unsigned i = 0; i < 5; i++) cyc("park", C_NONE);
      #1 chk("park_retired", {16'h0, retired}, {16'h0, exp_ret});

      // SUB with irun dropped mid-instruction: completes, then parks.
      irun   = 1'b1;
      opcode = 5'd4;
      cyc("sub_fetch", C_FETCH);
      irun = 1'b0;
      cyc("sub_loadir", C_LOADIR);
      cyc("sub_wait", C_NONE);
      cyc("sub_decode", C_NONE);
      cyc("sub_memrd", C_MEMRD);
      cyc("sub_alu", C_SUB);
      exp_ret = exp_ret + 16'd1;
      for (int unsigned i = 0; i < 3; i++) cyc("sub_parked", C_NONE);
      #1 chk("sub_retired", {16'h0, retired}, {16'h0, exp_ret});

      // HLT holds halted for 20 cycles and does not retire.
      irun   = 1'b1;
      opcode = 5'd31;
      cyc("hlt_fetch", C_FETCH);
      cyc("hlt_loadir", C_LOADIR);
      cyc("hlt_wait", C_NONE);
      cyc("hlt_decode", C_NONE);
      for (int unsigned i = 0; i < 20; i++) cyc("halt", C_HALT);
      #1 chk("hlt_retired", {16'h0, retired}, {16'h0, exp_ret});

      // Reset leaves halt; then STA interrupted by reset in S_STORE.
      irst_n = 1'b0;
      #1 chk("hlt_rst_ctl", {16'h0, ctl}, 32'h0);
      @(negedge iclk);
      irst_n  = 1'b1;
      exp_ret = '0;
      opcode  = 5'd2;
      address = 11'h0AA;
      cyc("sta2_fetch", C_FETCH);
      cyc("sta2_loadir", C_LOADIR);
      cyc("sta2_wait", C_NONE);
      cyc("sta2_decode", C_NONE);
      #1 chk("sta2_store", {16'h0, ctl}, {16'h0, C_STORE});
      irst_n = 1'b0;
      #1 chk("rst_mid_ctl", {16'h0, ctl}, 32'h0);
      chk("rst_mid_retired", {16'h0, retired}, 32'h0);
      @(negedge iclk);
      irst_n = 1'b1;
      instr("resume", 5'd0, 11'h000, 1'b0, 1'b0, C_NONE, C_NONE, C_NONE, 4);
      chk("resume_iraddr", {21'h0, ir_addr}, 32'h000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
